// File: rtl/id_stage_if.sv
// -----------------------------------------------------------------------------
// id_stage_if
//   Bundles the fetch/writeback-facing signals of the decode stage.
//   master : the fetch/writeback side (drives inst, pc, wb_*; sees branch and
//            ID/EX results).
//   slave  : the decode stage itself.
// Signals:
//   inst, pc                  fetched instruction word and its PC
//   wb_en, wb_addr, wb_data   register-file write port from writeback
//   branch_control/alu, br_pc branch resolution returned to fetch
//   ex_*                      registered ID/EX contents for execute
// -----------------------------------------------------------------------------
interface id_stage_if #(
    parameter int PCW = 11
);
    logic [31:0]    inst;
    logic [PCW-1:0] pc;
    logic           wb_en;
    logic [3:0]     wb_addr;
    logic [31:0]    wb_data;

    logic           branch_control;
    logic           branch_alu;
    logic [PCW-1:0] br_pc;

    logic           ex_valid;
    logic [3:0]     ex_opcode;
    logic [3:0]     ex_rd;
    logic [31:0]    ex_a;
    logic [31:0]    ex_b;
    logic [31:0]    ex_imm;
    logic [PCW-1:0] ex_pc;

    modport master (
        output inst, pc, wb_en, wb_addr, wb_data,
        input  branch_control, branch_alu, br_pc,
        input  ex_valid, ex_opcode, ex_rd, ex_a, ex_b, ex_imm, ex_pc
    );

    modport slave (
        input  inst, pc, wb_en, wb_addr, wb_data,
        output branch_control, branch_alu, br_pc,
        output ex_valid, ex_opcode, ex_rd, ex_a, ex_b, ex_imm, ex_pc
    );
endinterface

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
//   Instruction-decode stage. Registers the fetched instruction into IF/ID,
//   reads a 16x32 register file (r0 hard-wired to zero, write-through bypass),
//   resolves BEQZ / B branches for fetch and flushes the wrong-path slot on a
//   taken branch, then registers decoded operands into ID/EX.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low; clears pipeline registers and regfile
//   bus    id_stage_if.slave (fetch inputs, writeback port, branch and
//          ID/EX outputs)
// -----------------------------------------------------------------------------
module id_stage #(
    parameter int NREG = 16,
    parameter int PCW  = 11
) (
    input  logic       clk,
    input  logic       reset,
    id_stage_if.slave  bus
);

    localparam logic [3:0] OP_BEQZ = 4'b0110;
    localparam logic [3:0] OP_B    = 4'b1000;

    // IF/ID pipeline register
    logic [31:0]    id_inst_q, id_inst_d;
    logic [PCW-1:0] id_pc_q,   id_pc_d;
    logic           id_valid_q, id_valid_d;

    // ID/EX pipeline register
    logic           ex_valid_q;
    logic [3:0]     ex_opcode_q;
    logic [3:0]     ex_rd_q;
    logic [31:0]    ex_a_q;
    logic [31:0]    ex_b_q;
    logic [31:0]    ex_imm_q;
    logic [PCW-1:0] ex_pc_q;

    logic [31:0] rf_q [NREG];

    // Decoded fields of the instruction sitting in ID
    logic [3:0]  id_opcode, id_rd, id_rs, id_rt;
    logic [15:0] id_imm16;

    assign id_opcode = id_inst_q[31:28];
    assign id_rd     = id_inst_q[27:24];
    assign id_rs     = id_inst_q[23:20];
    assign id_rt     = id_inst_q[19:16];
    assign id_imm16  = id_inst_q[15:0];

    // Register read with write-through bypass so a same-cycle writeback is
    // visible to the instruction in ID (including a BEQZ testing it).
    logic [31:0] rs_val, rt_val;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch can never be inferred.
        rs_val = '0;
        rt_val = '0;
        if (id_rs != 4'd0) begin
            if (bus.wb_en && bus.wb_addr == id_rs) rs_val = bus.wb_data;
            else                                   rs_val = rf_q[id_rs];
        end
        if (id_rt != 4'd0) begin
            if (bus.wb_en && bus.wb_addr == id_rt) rt_val = bus.wb_data;
            else                                   rt_val = rf_q[id_rt];
        end
    end

    // Branch resolution, gated by id_valid so bubbles and reset never branch.
    logic           branch_control, branch_alu, take;
    logic [PCW-1:0] br_target;

    always_comb begin
        branch_control = 1'b0;
        branch_alu     = 1'b0;
        if (id_valid_q) begin
            case (id_opcode)
                OP_BEQZ: begin
                    branch_control = 1'b1;
                    branch_alu     = (rs_val == 32'd0);
                end
                OP_B: begin
                    branch_control = 1'b1;
                    branch_alu     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign take = branch_control & branch_alu;

    // Target wraps modulo 2^PCW; only the low PCW bits of imm16 contribute.
    assign br_target = id_pc_q + PCW'(1) + id_imm16[PCW-1:0];

    // IF/ID next state: a taken branch replaces the wrong-path fetch with a bubble.
    always_comb begin
        id_inst_d  = bus.inst;
        id_pc_d    = bus.pc;
        id_valid_d = 1'b1;
        if (take) begin
            id_inst_d  = '0;
            id_pc_d    = '0;
            id_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_inst_q  <= '0;
            id_pc_q    <= '0;
            id_valid_q <= 1'b0;
        end else begin
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
        end
    end

    // NOTE: the register file is deliberately reset (reset must clear all 16
    // entries), which rules out mapping it onto a RAM macro; it is flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (bus.wb_en && bus.wb_addr != 4'd0) begin
            rf_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    // ID/EX: bubbles propagate with ex_valid=0; branches pass with ex_valid=1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q  <= 1'b0;
            ex_opcode_q <= '0;
            ex_rd_q     <= '0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            ex_imm_q    <= '0;
            ex_pc_q     <= '0;
        end else begin
            ex_valid_q  <= id_valid_q;
            ex_opcode_q <= id_opcode;
            ex_rd_q     <= id_rd;
            ex_a_q      <= rs_val;
            ex_b_q      <= rt_val;
            ex_imm_q    <= {{16{id_imm16[15]}}, id_imm16};
            ex_pc_q     <= id_pc_q;
        end
    end

    // br_pc is only meaningful for a branch; hold it at zero otherwise so the
    // idle/reset value is clean.
    assign bus.branch_control = branch_control;
    assign bus.branch_alu     = branch_alu;
    assign bus.br_pc          = branch_control ? br_target : '0;

    assign bus.ex_valid  = ex_valid_q;
    assign bus.ex_opcode = ex_opcode_q;
    assign bus.ex_rd     = ex_rd_q;
    assign bus.ex_a      = ex_a_q;
    assign bus.ex_b      = ex_b_q;
    assign bus.ex_imm    = ex_imm_q;
    assign bus.ex_pc     = ex_pc_q;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage
//   Directed testbench for id_stage. The bench plays the fetch and writeback
//   roles, driving inst/pc/wb_* directly, and compares outputs against
//   hand-computed values.
// -----------------------------------------------------------------------------
module tb_id_stage;

    logic clk;
    logic reset;

    int checks;
    int errors;

    id_stage_if #(.PCW(11)) bus ();

    id_stage #(.NREG(16), .PCW(11)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [3:0] rt,
                                        input logic [15:0] imm);
        return {op, rd, rs, rt, imm};
    endfunction

    task automatic fetch(input logic [31:0] i, input logic [10:0] p);
        bus.inst = i;
        bus.pc   = p;
    endtask

    task automatic wb(input logic en, input logic [3:0] a, input logic [31:0] d);
        bus.wb_en   = en;
        bus.wb_addr = a;
        bus.wb_data = d;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        fetch(32'd0, 11'd0);
        wb(1'b0, 4'd0, 32'd0);

        // Reset state
        #3;
        check("rst_bc",     32'(bus.branch_control), 32'd0);
        check("rst_ba",     32'(bus.branch_alu),     32'd0);
        check("rst_brpc",   32'(bus.br_pc),          32'd0);
        check("rst_exv",    32'(bus.ex_valid),       32'd0);
        check("rst_exa",    bus.ex_a,                32'd0);
        check("rst_eximm",  bus.ex_imm,              32'd0);
        @(negedge clk);
        reset = 1'b1;

        // NOP through the pipe
        fetch(32'd0, 11'd5);
        tick();
        check("nop_bc",     32'(bus.branch_control), 32'd0);
        check("nop_brpc",   32'(bus.br_pc),          32'd0);
        check("nop_exv0",   32'(bus.ex_valid),       32'd0);
        tick();
        check("nop_exv1",   32'(bus.ex_valid),       32'd1);
        check("nop_exop",   32'(bus.ex_opcode),      32'd0);
        check("nop_expc",   32'(bus.ex_pc),          32'd5);

        // Write r1=0xD, decode 0x21000001, then read r1 as rs
        wb(1'b1, 4'd1, 32'h0000_000D);
        fetch(32'h2100_0001, 11'd10);
        tick();
        wb(1'b0, 4'd0, 32'd0);
        fetch(enc(4'd3, 4'd4, 4'd1, 4'd0, 16'd0), 11'd11);
        tick();
        check("alu_exop",   32'(bus.ex_opcode),      32'd2);
        check("alu_exrd",   32'(bus.ex_rd),          32'd1);
        check("alu_eximm",  bus.ex_imm,              32'd1);
        check("alu_expc",   32'(bus.ex_pc),          32'd10);
        fetch(32'd0, 11'd12);
        tick();
        check("rd_r1_exa",  bus.ex_a,                32'h0000_000D);
        check("rd_r1_exrd", 32'(bus.ex_rd),          32'd4);

        // Taken BEQZ on r0 at pc 7, imm 5
        fetch(enc(4'd6, 4'd0, 4'd0, 4'd0, 16'd5), 11'd7);
        tick();
        check("beqz0_bc",   32'(bus.branch_control), 32'd1);
        check("beqz0_ba",   32'(bus.branch_alu),     32'd1);
        check("beqz0_brpc", 32'(bus.br_pc),          32'd13);
        fetch(enc(4'd2, 4'd5, 4'd1, 4'd0, 16'h0022), 11'd8);   // wrong path
        tick();
        check("flush_bc",   32'(bus.branch_control), 32'd0);
        check("br_exv",     32'(bus.ex_valid),       32'd1);
        check("br_exop",    32'(bus.ex_opcode),      32'd6);
        fetch(enc(4'd3, 4'd6, 4'd1, 4'd0, 16'd0), 11'd13);     // target
        tick();
        check("bubble_exv", 32'(bus.ex_valid),       32'd0);
        fetch(32'd0, 11'd14);
        tick();
        check("tgt_exv",    32'(bus.ex_valid),       32'd1);
        check("tgt_exop",   32'(bus.ex_opcode),      32'd3);
        check("tgt_expc",   32'(bus.ex_pc),          32'd13);

        // BEQZ on r2=9: not taken, no flush
        wb(1'b1, 4'd2, 32'd9);
        fetch(32'd0, 11'd20);
        tick();
        wb(1'b0, 4'd0, 32'd0);
        fetch(enc(4'd6, 4'd0, 4'd2, 4'd0, 16'd4), 11'd21);
        tick();
        check("beqz9_bc",   32'(bus.branch_control), 32'd1);
        check("beqz9_ba",   32'(bus.branch_alu),     32'd0);
        check("beqz9_brpc", 32'(bus.br_pc),          32'd26);
        fetch(32'd0, 11'd22);
        tick();
        fetch(enc(4'd6, 4'd0, 4'd2, 4'd0, 16'd4), 11'd23);
        tick();
        check("noflush_exv", 32'(bus.ex_valid),      32'd1);
        check("noflush_expc", 32'(bus.ex_pc),        32'd22);
        check("beqz9b_ba",  32'(bus.branch_alu),     32'd0);
        // Same-cycle writeback r2=0 makes the BEQZ taken via bypass
        wb(1'b1, 4'd2, 32'd0);
        #1;
        check("byp_ba",     32'(bus.branch_alu),     32'd1);
        check("byp_brpc",   32'(bus.br_pc),          32'd28);
        fetch(enc(4'd1, 4'd1, 4'd0, 4'd0, 16'd0), 11'd24);     // wrong path
        tick();
        wb(1'b0, 4'd0, 32'd0);
        check("byp_exa",    bus.ex_a,                32'd0);
        check("byp_expc",   32'(bus.ex_pc),          32'd23);
        check("byp_flush",  32'(bus.branch_control), 32'd0);

        // Unconditional B at 2046 with imm 3 wraps to 2
        fetch(enc(4'd8, 4'd0, 4'd0, 4'd0, 16'd3), 11'd2046);
        tick();
        check("b_bc",       32'(bus.branch_control), 32'd1);
        check("b_ba",       32'(bus.branch_alu),     32'd1);
        check("b_wrap",     32'(bus.br_pc),          32'd2);
        fetch(32'd0, 11'd2047);
        tick();

        // Write to r0 is ignored and not bypassed; negative immediate
        wb(1'b1, 4'd0, 32'h0000_DEAD);
        fetch(enc(4'd1, 4'd3, 4'd0, 4'd0, 16'hFFFF), 11'd2);
        tick();
        check("b_bubble_exv", 32'(bus.ex_valid),     32'd0);
        fetch(32'd0, 11'd3);
        tick();
        wb(1'b0, 4'd0, 32'd0);
        check("r0_exa",     bus.ex_a,                32'd0);
        check("neg_eximm",  bus.ex_imm,              32'hFFFF_FFFF);
        check("neg_exrd",   32'(bus.ex_rd),          32'd3);

        // Asynchronous reset while a branch sits in ID
        fetch(enc(4'd8, 4'd0, 4'd0, 4'd0, 16'd1), 11'd100);
        tick();
        check("pre_rst_bc", 32'(bus.branch_control), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_bc",    32'(bus.branch_control), 32'd0);
        check("arst_ba",    32'(bus.branch_alu),     32'd0);
        check("arst_brpc",  32'(bus.br_pc),          32'd0);
        check("arst_exv",   32'(bus.ex_valid),       32'd0);
        check("arst_expc",  32'(bus.ex_pc),          32'd0);
        #2;
        reset = 1'b1;
        // r1 held 0xD before reset; it must read back as 0 now
        fetch(enc(4'd1, 4'd0, 4'd1, 4'd2, 16'd0), 11'd0);
        tick();
        fetch(32'd0, 11'd1);
        tick();
        check("arst_rf_r1", bus.ex_a,                32'd0);
        check("arst_rf_r2", bus.ex_b,                32'd0);
        check("arst_exv1",  32'(bus.ex_valid),       32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
